// File: rtl/bitutils.sv
// bitutils: shared bit-level types used across the memory subsystem.
//   dword_t : 64-bit data word
package bitutils;

  typedef logic [63:0] dword_t;

endpackage

// File: rtl/rand_arb_pkg.sv
// rand_arb_pkg: types, constants and the LFSR step function for rand_arbiter.
//   rand_arb_state_e : WARMUP (LFSR spinning, no grants) / SERVE (granting)
//   RAND_LFSR_TAPS   : feedback taps of the 64-bit Fibonacci LFSR (bits 0,1,3,4)
//   lfsr_step()      : one shift of the LFSR, with lock-up guard
package rand_arb_pkg;
  import bitutils::*;

  typedef enum logic {
    WARMUP = 1'b0,
    SERVE  = 1'b1
  } rand_arb_state_e;

  localparam dword_t RAND_LFSR_TAPS = 64'h0000_0000_0000_001B;

  // All-zero is a fixed point of an XOR LFSR; kick it out to 1 so the
  // generator can never stall forever.
  function automatic dword_t lfsr_step(input dword_t l);
    if (l == '0) return 64'h1;
    return {^(l & RAND_LFSR_TAPS), l[63:1]};
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin picker.
//   pending : request bits
//   ptr     : index of the last winner; search starts at ptr+1 and wraps
//   onehot  : one-hot winner (0 when nothing pending)
//   idx     : binary index of the winner
//   any     : at least one bit pending
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  int          pos;
  logic [IW-1:0] cand;
  logic        found;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = 0;
    cand   = '0;
    // Walk ptr+1 .. ptr+N modulo N; the first set bit wins, so the last
    // winner is the lowest priority next time.
    for (int off = 1; off <= N; off++) begin
      pos = int'(ptr) + off;
      if (pos >= N) pos = pos - N;
      cand = IW'(pos);
      if (!found && pending[cand]) begin
        found        = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

  assign any = |pending;

endmodule

// File: rtl/rand_arbiter.sv
// rand_arbiter: one shared 64-bit Fibonacci LFSR handed out to NUM_REQ
// requesters. Request pulses are latched into pending bits; at most one is
// granted per cycle in round-robin order, together with the current LFSR word.
// The LFSR steps exactly once per grant, so every consumer sees a fresh word.
// After reset (or reseed) the LFSR first spins WARMUP_CYCLES times.
//
// Ports:
//   clk      clock
//   rst      asynchronous active-high reset
//   req_i    [NUM_REQ] one-cycle request pulses
//   gnt_o    [NUM_REQ] registered one-hot grant, valid for one cycle
//   rand_o   [64]      random word, valid while |gnt_o; holds otherwise
//   ready_o            high while in SERVE
//   reseed_i, seed_i   only with RAND_ARB_RESEED_EN: reload LFSR and re-warm
//
// Build option: define RAND_ARB_RESEED_EN to add the runtime reseed ports.
module rand_arbiter
  import bitutils::*;
  import rand_arb_pkg::*;
#(
  parameter int     NUM_REQ       = 4,
  parameter dword_t RANDOM_SEED   = 64'h1234_5678_8765_4321,
  parameter int     WARMUP_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
`ifdef RAND_ARB_RESEED_EN
  input  logic               reseed_i,
  input  dword_t             seed_i,
`endif
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output dword_t             rand_o,
  output logic               ready_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (WARMUP_CYCLES < 1) ? 1 : $clog2(WARMUP_CYCLES + 1);

  rand_arb_state_e    state;
  logic [CW-1:0]      cnt;
  logic [NUM_REQ-1:0] pending;
  logic [IW-1:0]      rr_ptr;
  dword_t             lfsr;
  dword_t             lfsr_next;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  assign lfsr_next = lfsr_step(lfsr);

  rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
    .pending (pending),
    .ptr     (rr_ptr),
    .onehot  (pick_onehot),
    .idx     (pick_idx),
    .any     (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= WARMUP;
      cnt     <= CW'(WARMUP_CYCLES);
      pending <= '0;
      rr_ptr  <= IW'(NUM_REQ - 1);
      lfsr    <= RANDOM_SEED;
      gnt_o   <= '0;
      rand_o  <= '0;
      ready_o <= 1'b0;
    end else begin
`ifdef RAND_ARB_RESEED_EN
      // Reseed wins over any grant this edge; queued requests survive it.
      if (reseed_i) begin
        lfsr    <= (seed_i == '0) ? 64'h1 : seed_i;
        cnt     <= CW'(WARMUP_CYCLES);
        state   <= WARMUP;
        ready_o <= 1'b0;
        gnt_o   <= '0;
        pending <= pending | req_i;
      end else
`endif
      begin
        case (state)
          WARMUP: begin
            gnt_o   <= '0;
            pending <= pending | req_i;
            if (cnt != '0) begin
              lfsr <= lfsr_next;
              cnt  <= cnt - CW'(1);
            end else begin
              state   <= SERVE;
              ready_o <= 1'b1;
            end
          end
          SERVE: begin
            if (pick_any) begin
              gnt_o   <= pick_onehot;
              rand_o  <= lfsr;
              lfsr    <= lfsr_next;
              rr_ptr  <= pick_idx;
              // A fresh pulse on the winner's line re-arms it for a later grant.
              pending <= (pending & ~pick_onehot) | req_i;
            end else begin
              gnt_o   <= '0;
              pending <= pending | req_i;
            end
          end
          default: begin
            state <= WARMUP;
            gnt_o <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rand_arbiter.sv
module tb_rand_arbiter;

  localparam logic [63:0] SEED = 64'h1234_5678_8765_4321;

  logic        clk = 1'b0;
  logic        rst0, rst16;
  logic [3:0]  req0, req16;
  logic [3:0]  gnt0, gnt16;
  logic [63:0] rand0, rand16;
  logic        ready0, ready16;
`ifdef RAND_ARB_RESEED_EN
  logic        reseed0 = 1'b0, reseed16 = 1'b0;
  logic [63:0] seed0 = '0, seed16 = '0;
`endif

  typedef struct packed {
    logic [3:0]  g;
    logic [63:0] r;
  } exp_t;

  exp_t        q0[$], q16[$];
  exp_t        e0, e16, ep;
  logic [63:0] m0, m16;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  rand_arbiter #(.NUM_REQ(4), .RANDOM_SEED(SEED), .WARMUP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0),
`ifdef RAND_ARB_RESEED_EN
    .reseed_i(reseed0), .seed_i(seed0),
`endif
    .req_i(req0), .gnt_o(gnt0), .rand_o(rand0), .ready_o(ready0)
  );

  rand_arbiter #(.NUM_REQ(4), .RANDOM_SEED(SEED), .WARMUP_CYCLES(16)) dut16 (
    .clk(clk), .rst(rst16),
`ifdef RAND_ARB_RESEED_EN
    .reseed_i(reseed16), .seed_i(seed16),
`endif
    .req_i(req16), .gnt_o(gnt16), .rand_o(rand16), .ready_o(ready16)
  );

  function automatic logic [63:0] step(input logic [63:0] l);
    if (l == 64'h0) return 64'h1;
    return {l[0] ^ l[1] ^ l[3] ^ l[4], l[63:1]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Push an expected grant for dut0 using the model LFSR, then advance it.
  task automatic push0(input logic [3:0] g);
    ep.g = g; ep.r = m0; q0.push_back(ep); m0 = step(m0);
  endtask

  task automatic push16(input logic [3:0] g);
    ep.g = g; ep.r = m16; q16.push_back(ep); m16 = step(m16);
  endtask

  // Scoreboard: every observed grant must match the oldest expectation.
  always @(negedge clk) begin
    if (gnt0 !== 4'b0) begin
      if (q0.size() == 0) check("spurious_gnt0", {60'b0, gnt0}, 64'h0);
      else begin
        e0 = q0.pop_front();
        check("gnt0", {60'b0, gnt0}, {60'b0, e0.g});
        check("rand0", rand0, e0.r);
      end
    end
  end

  always @(negedge clk) begin
    if (gnt16 !== 4'b0) begin
      if (q16.size() == 0) check("spurious_gnt16", {60'b0, gnt16}, 64'h0);
      else begin
        e16 = q16.pop_front();
        check("gnt16", {60'b0, gnt16}, {60'b0, e16.g});
        check("rand16", rand16, e16.r);
      end
    end
  end

  initial begin
    rst0 = 1'b1; rst16 = 1'b1; req0 = '0; req16 = '0;
    m0 = SEED; m16 = SEED;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_gnt0",    {60'b0, gnt0}, 64'h0);
    check("rst_rand0",   rand0, 64'h0);
    check("rst_ready0",  {63'b0, ready0}, 64'h0);
    check("rst_gnt16",   {60'b0, gnt16}, 64'h0);
    check("rst_rand16",  rand16, 64'h0);
    check("rst_ready16", {63'b0, ready16}, 64'h0);

    // 16-cycle warmup: requests latched during warmup, served in order after
    rst16 = 1'b0;
    req16 = 4'b1111;
    @(negedge clk);
    req16 = 4'b0;
    for (int i = 0; i < 16; i++) m16 = step(m16);
    push16(4'b0001); push16(4'b0010); push16(4'b0100); push16(4'b1000);
    repeat (14) @(negedge clk);
    @(negedge clk);
    check("ready16_at16", {63'b0, ready16}, 64'h0);
    @(negedge clk);
    check("ready16_at17", {63'b0, ready16}, 64'h1);
    repeat (6) @(negedge clk);

    // no warmup: ready one edge after release
    rst0 = 1'b0;
    #1 check("ready0_release", {63'b0, ready0}, 64'h0);
    @(negedge clk);
    check("ready0_serve", {63'b0, ready0}, 64'h1);

    // first two words from the seed
    req0 = 4'b0001;
    ep.g = 4'b0001; ep.r = SEED; q0.push_back(ep);
    @(negedge clk); req0 = '0;
    @(negedge clk);
    @(negedge clk);
    check("idle_gnt0", {60'b0, gnt0}, 64'h0);
    check("idle_hold0", rand0, SEED);
    req0 = 4'b0001;
    ep.g = 4'b0001; ep.r = 64'h891A_2B3C_43B2_A190; q0.push_back(ep);
    m0 = step(64'h891A_2B3C_43B2_A190);
    @(negedge clk); req0 = '0;
    repeat (3) @(negedge clk);

    // all four at once, starting after last winner 0
    req0 = 4'b1111;
    push0(4'b0010); push0(4'b0100); push0(4'b1000); push0(4'b0001);
    @(negedge clk); req0 = '0;
    repeat (6) @(negedge clk);

    // single request moves pointer to 2
    req0 = 4'b0100;
    push0(4'b0100);
    @(negedge clk); req0 = '0;
    repeat (3) @(negedge clk);

    // merged pulses on line 2 while blocked, plus one on its grant edge
    req0 = 4'b1111;
    push0(4'b1000); push0(4'b0001); push0(4'b0010); push0(4'b0100); push0(4'b0100);
    @(negedge clk); req0 = 4'b0100;
    repeat (3) @(negedge clk);
    @(negedge clk); req0 = '0;
    repeat (4) @(negedge clk);

    // reset with requests pending
    req0 = 4'b0111;
    push0(4'b0001);
    @(negedge clk); req0 = '0;
    @(negedge clk);
    check("pre_rst_gnt0", {60'b0, gnt0}, 64'h1);
    #2 rst0 = 1'b1;
    #1;
    check("async_rst_gnt0",   {60'b0, gnt0}, 64'h0);
    check("async_rst_ready0", {63'b0, ready0}, 64'h0);
    check("async_rst_rand0",  rand0, 64'h0);
    m0 = SEED;
    @(negedge clk); rst0 = 1'b0;
    repeat (6) @(negedge clk);
    req0 = 4'b0010;
    push0(4'b0010);
    @(negedge clk); req0 = '0;
    repeat (3) @(negedge clk);

`ifdef RAND_ARB_RESEED_EN
    // reseed with zero seed collides with a pending request
    req0 = 4'b0001;
    @(negedge clk); req0 = '0; reseed0 = 1'b1; seed0 = 64'h0;
    @(negedge clk); reseed0 = 1'b0;
    check("reseed_gnt0",   {60'b0, gnt0}, 64'h0);
    check("reseed_ready0", {63'b0, ready0}, 64'h0);
    m0 = 64'h1;
    push0(4'b0001);
    repeat (4) @(negedge clk);
`endif

    check("q0_drained",  64'(q0.size()), 64'h0);
    check("q16_drained", 64'(q16.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
